// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared 7-segment encodings (active-low {g,f,e,d,c,b,a}) and
// the digit-index sizing helper for the display scanner.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: active-low 7-segment decode of one BCD nibble; 10-15 show a dash.
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = (bcd < 4'd10) ? SEG_DIGIT[bcd] : SEG_DASH;

endmodule

// File: rtl/bcd_display_scan.sv
// bcd_display_scan: time-multiplexed common-anode 7-segment scanner with set-mode blink.
// Optional LEADING_ZERO_BLANK_EN blanks a zero in the leftmost digit outside set mode.
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int                    NUM_DIGITS   = 6,
    parameter int                    REFRESH_DIV  = 50000,
    parameter int                    BLINK_FRAMES = 25,
    parameter logic [NUM_DIGITS-1:0] DP_MASK      = 6'b010100
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic                      set_ena,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an
);

    localparam int IW = idx_width(NUM_DIGITS);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [PW-1:0]         p_q, p_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [FW-1:0]         frame_q, frame_d;
    logic                  phase_q, phase_d;
    logic [3:0]            nib_q, nib_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [6:0]            seg_dec;
    logic                  wrap_slot, wrap_idx, frame_end, blank, lit;

    bcd_to_7seg u_dec (
        .bcd (nib_q),
        .seg (seg_dec)
    );

    always_comb begin
        wrap_slot = p_q == PW'(REFRESH_DIV - 1);
        wrap_idx  = idx_q == IW'(NUM_DIGITS - 1);
        frame_end = frame_q == FW'(BLINK_FRAMES - 1);
        p_d       = wrap_slot ? '0 : p_q + 1'b1;
        idx_d     = wrap_slot ? (wrap_idx ? '0 : idx_q + 1'b1) : idx_q;
        nib_d     = wrap_slot ? bcd_in[{idx_d, 2'b00} +: 4] : nib_q;
        frame_d   = (wrap_slot && wrap_idx) ? (frame_end ? '0 : frame_q + 1'b1) : frame_q;
        phase_d   = phase_q ^ (wrap_slot && wrap_idx && frame_end);
        blank     = set_ena && !phase_q && blink_mask[idx_q];
`ifdef LEADING_ZERO_BLANK_EN
        blank     = blank || (wrap_idx && nib_q == 4'd0 && !set_ena);
`endif
        // the p = 0 cycle of every slot is dead time between anodes
        lit       = (p_q != '0) && !blank;
        an_d      = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        seg_d     = lit ? seg_dec : SEG_BLANK;
        dp_d      = lit ? ~DP_MASK[idx_q] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            p_q     <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            phase_q <= 1'b1;
            nib_q   <= bcd_in[3:0];
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            p_q     <= p_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
            nib_q   <= nib_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: time-indexed reference model plus hand-computed spot checks
// for the display scanner at NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2.
module tb_bcd_display_scan;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int BF = 2;
    localparam logic [3:0] DPM = 4'b0100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] bcd_in = 16'h0000;
    logic        set_ena = 1'b0;
    logic [3:0]  blink_mask = 4'b0000;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

    bcd_display_scan #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .BLINK_FRAMES (BF),
        .DP_MASK      (DPM)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bcd_in     (bcd_in),
        .set_ena    (set_ena),
        .blink_mask (blink_mask),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    always #5 clk = ~clk;

    logic [6:0] dec [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    // k = cycles elapsed since the last reset edge; the scan position is pure arithmetic on k
    int         k = 0;
    logic [3:0] lat = 4'h0;
    logic [3:0] e_an = 4'hF;
    logic [6:0] e_seg = 7'h7F;
    logic       e_dp = 1'b1;
    bit         valid = 1'b0;

    always @(posedge clk) begin : model
        int p, idx, f;
        bit ph, bl;
        if (!reset_n) begin
            k = 0;
            lat = bcd_in[3:0];
            e_an = 4'hF;
            e_seg = 7'h7F;
            e_dp = 1'b1;
            valid = 1'b1;
        end else begin
            p   = k % R;
            idx = (k / R) % N;
            f   = k / (R * N);
            ph  = ((f / BF) % 2) == 0;
            bl  = set_ena && !ph && blink_mask[idx];
`ifdef LEADING_ZERO_BLANK_EN
            bl  = bl || (idx == N - 1 && lat == 4'h0 && !set_ena);
`endif
            if (p == 0 || bl) begin
                e_an = 4'hF;
                e_seg = 7'h7F;
                e_dp = 1'b1;
            end else begin
                e_an = ~(4'b0001 << idx);
                e_seg = dec[lat];
                e_dp = ~DPM[idx];
            end
            k++;
            if (k % R == 0) lat = bcd_in[4 * ((k / R) % N) +: 4];
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            checks++;
            if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
                errors++;
                $display("FAIL model k=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         k, an, seg, dp, e_an, e_seg, e_dp);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic go(input int target);
        for (int i = 0; i < 2000 && k < target; i++) @(negedge clk);
        if (k != target) begin
            checks++;
            errors++;
            $display("FAIL timeout k=%0d want %0d", k, target);
        end
    endtask

    task automatic do_reset(input logic [15:0] b, input logic se, input logic [3:0] bm);
        @(negedge clk);
        reset_n = 1'b0;
        bcd_in = b;
        set_ena = se;
        blink_mask = bm;
        @(negedge clk);
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_dp", 32'(dp), 32'h1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] an_seq [8];
        int dead, lit_cnt [4], lit3;
        an_seq = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1101};

        // scan, wrap and slot timing
        do_reset(16'h1259, 1'b0, 4'b0000);
        for (int j = 1; j <= 8; j++) begin
            go(j);
            chk($sformatf("scan_an_%0d", j), 32'(an), 32'(an_seq[j-1]));
            if (j == 2) chk("seg_slot0", 32'(seg), 32'b0010000);
            if (j == 6) chk("seg_slot1", 32'(seg), 32'b0010010);
            if (j == 6) chk("dp_slot1", 32'(dp), 32'h1);
        end
        go(10);
        chk("dp_slot2", 32'(dp), 32'h0);
        do_reset(16'h1259, 1'b0, 4'b0000);
        dead = 0;
        lit_cnt = '{0, 0, 0, 0};
        for (int j = 1; j <= 48; j++) begin
            go(j);
            if (an == 4'hF) dead++;
            for (int d = 0; d < 4; d++) if (an == ~(4'b0001 << d)) lit_cnt[d]++;
        end
        chk("dead_cycles", 32'(dead), 32'd12);
        for (int d = 0; d < 4; d++) chk($sformatf("lit_idx%0d", d), 32'(lit_cnt[d]), 32'd9);
        go(55);

        // mid-operation reset, then invalid digit and mid-slot update
        do_reset(16'h12C9, 1'b0, 4'b0000);
        go(6);
        chk("dash_slot1", 32'(seg), 32'b0111111);
        go(17);
        bcd_in[3:0] = 4'h3;
        go(18);
        chk("midslot_hold_a", 32'(seg), 32'b0010000);
        go(20);
        chk("midslot_hold_b", 32'(seg), 32'b0010000);
        go(34);
        chk("next_frame_new", 32'(seg), 32'b0110000);

        // blink in set mode
        do_reset(16'h1259, 1'b1, 4'b1100);
        go(10);
        chk("blink_vis_f0", 32'(an), 32'b1011);
        go(34);
        chk("blink_f2_d0", 32'(an), 32'b1110);
        go(42);
        chk("blink_f2_d2", 32'(an), 32'b1111);
        go(46);
        chk("blink_f2_d3", 32'(an), 32'b1111);
        go(58);
        chk("blink_f3_d2", 32'(an), 32'b1111);
        set_ena = 1'b0;
        go(59);
        chk("unblank_d2", 32'(an), 32'b1011);
        go(70);

        // leftmost zero digit
        do_reset(16'h0905, 1'b0, 4'b0000);
        lit3 = 0;
        for (int j = 1; j <= 32; j++) begin
            go(j);
            if (an[3] == 1'b0) lit3++;
        end
`ifdef LEADING_ZERO_BLANK_EN
        chk("lzb_d3_lit", 32'(lit3), 32'd0);
`else
        chk("lzb_d3_lit", 32'(lit3), 32'd6);
`endif
        do_reset(16'h0905, 1'b1, 4'b0000);
        go(14);
        chk("set_d3_an", 32'(an), 32'b0111);
        chk("set_d3_seg", 32'(seg), 32'b1000000);
        go(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
